// File: rtl/memory_ctrl.sv
// Single-port word memory with a self-clearing sequencer, pipelined registered
// reads (1 or 2 edges) and a pulse flagging requests dropped while clearing.
module memory_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] data_in,
  input  logic              init_req,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              acc_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic              busy_reg;
  logic              acc_err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_fire;
  logic              rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign wr_fire = (state_reg == READY) && write_en;
  assign rd_fire = (state_reg == READY) && read_en;

  // One shared write port: the clear sequencer owns it while in CLEAR.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = add;
    mem_wdata = data_in;
    if (rst_n) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_reg;
        mem_wdata = '0;
      end else if (wr_fire) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
      acc_err_reg <= 1'b0;
    end else begin
      acc_err_reg <= (state_reg == CLEAR) && (write_en || read_en);
      case (state_reg)
        CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
          if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
          end
        end
        READY: begin
          if (init_req) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        default: begin
          state_reg <= CLEAR;
        end
      endcase
    end
  end

  // Read pipeline: stage 0 is the RAM output register, later stages only
  // load when the previous stage holds a valid word so data_out stays put.
  logic [DATA_W-1:0] pipe_data_reg  [READ_LAT];
  logic              pipe_valid_reg [READ_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_data_reg[0]  <= '0;
      pipe_valid_reg[0] <= 1'b0;
    end else begin
      pipe_valid_reg[0] <= rd_fire;
      if (rd_fire) begin
        // Shared address: a simultaneous write always targets the read word.
        if (RDW_MODE != 0 && wr_fire) begin
          pipe_data_reg[0] <= data_in;
        end else begin
          pipe_data_reg[0] <= mem[add];
        end
      end
    end
  end

  for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_rd_stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_data_reg[gi]  <= '0;
        pipe_valid_reg[gi] <= 1'b0;
      end else begin
        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
        if (pipe_valid_reg[gi-1]) begin
          pipe_data_reg[gi] <= pipe_data_reg[gi-1];
        end
      end
    end
  end

  assign data_out = pipe_data_reg[READ_LAT-1];
  assign rd_valid = pipe_valid_reg[READ_LAT-1];
  assign busy     = busy_reg;
  assign acc_err  = acc_err_reg;

endmodule
